// File: rtl/spi_cfg_arbiter.sv
// spi_cfg_arbiter: gives the SPI transaction path and the internal master shared
// access to the configuration/status register bank. SPI requests wait in a small
// FIFO because the SPI side cannot stall; the internal master uses valid/ready.
// Each access takes three cycles (grant, bank strobe, response capture), and
// requests that are both pending are served in strict alternation.
module spi_cfg_arbiter #(
  parameter int NUM_REGS       = 60,
  parameter int WR_LO          = 1,
  parameter int WR_HI          = 3,
  parameter int SPI_FIFO_DEPTH = 2
) (
  input  logic       iclk,
  input  logic       rstn,
  input  logic       spi_req_valid,
  input  logic       spi_req_we,
  input  logic [7:0] spi_req_addr,
  input  logic [7:0] spi_req_data,
  output logic       spi_rsp_valid,
  output logic [7:0] spi_rsp_data,
  output logic       spi_rsp_err,
  output logic       spi_ovf,
  input  logic       ovf_clr,
  input  logic       int_req_valid,
  output logic       int_req_ready,
  input  logic       int_req_we,
  input  logic [7:0] int_req_addr,
  input  logic [7:0] int_req_data,
  output logic       int_rsp_valid,
  output logic [7:0] int_rsp_data,
  output logic       int_rsp_err,
  output logic [7:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_data,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rd_data
);

  localparam int AW = $clog2(SPI_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT} state_t;

  state_t      state, state_nxt;

  logic [16:0] fifo_mem [SPI_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, fifo_push, fifo_pop, ovf_set;
  logic [16:0] fifo_head;

  logic        last_int;
  logic        grant_spi, grant_int, grant;
  logic        sel_we, sel_err;
  logic [7:0]  sel_addr, sel_data;

  logic        lat_int, lat_we, lat_err;
  logic [7:0]  lat_data;
  logic [7:0]  rsp_value;

  // Map legality: writes only inside [WR_LO, WR_HI]; reads anywhere except the
  // reserved address 0 and beyond the decoded range. No upper-bit aliasing.
  function automatic logic access_err(input logic we, input logic [7:0] addr);
    if (we)
      return ({1'b0, addr} < 9'(WR_LO)) || ({1'b0, addr} > 9'(WR_HI));
    else
      return (addr == 8'd0) || ({1'b0, addr} >= 9'(NUM_REGS));
  endfunction

  // Writes echo their data whether or not they were legal; bad reads return 0.
  function automatic logic [7:0] resp_data(input logic we, input logic err,
                                           input logic [7:0] wdata,
                                           input logic [7:0] rdata);
    if (we)       return wdata;
    else if (err) return 8'd0;
    else          return rdata;
  endfunction

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

  // Next-state and round-robin grant; the loser of the last tie wins the next.
  always_comb begin
    state_nxt = state;
    grant_spi = 1'b0;
    grant_int = 1'b0;
    case (state)
      IDLE: begin
        grant_spi = !fifo_empty && (!int_req_valid || last_int);
        grant_int = int_req_valid && (fifo_empty || !last_int);
        if (grant_spi || grant_int) state_nxt = EXEC;
      end
      EXEC:    state_nxt = CAPT;
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant         = grant_spi || grant_int;
  assign int_req_ready = grant_int;
  assign sel_we        = grant_spi ? fifo_head[16]    : int_req_we;
  assign sel_addr      = grant_spi ? fifo_head[15:8]  : int_req_addr;
  assign sel_data      = grant_spi ? fifo_head[7:0]   : int_req_data;
  assign sel_err       = access_err(sel_we, sel_addr);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign fifo_pop  = grant_spi;
  assign fifo_push = spi_req_valid && (!fifo_full || fifo_pop);
  assign ovf_set   = spi_req_valid && fifo_full && !fifo_pop;
  assign rsp_value = resp_data(lat_we, lat_err, lat_data, reg_rd_data);

  // FSM state register.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // FIFO storage and the latched access; only meaningful behind valid state.
  always_ff @(posedge iclk) begin
    if (fifo_push) fifo_mem[wr_ptr[AW-1:0]] <= {spi_req_we, spi_req_addr, spi_req_data};
    if (grant) begin
      lat_int  <= grant_int;
      lat_we   <= sel_we;
      lat_data <= sel_data;
      lat_err  <= sel_err;
    end
  end

  // FIFO pointers, RR pointer and sticky overflow flag.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_int <= 1'b1;
      spi_ovf  <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (grant_spi) last_int <= 1'b0;
      if (grant_int) last_int <= 1'b1;
      if (ovf_set)      spi_ovf <= 1'b1;
      else if (ovf_clr) spi_ovf <= 1'b0;
    end
  end

  // Bank strobes on grant, response pulse to the issuing side on capture.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      reg_addr      <= 8'd0;
      reg_wr_data   <= 8'd0;
      reg_wr_en     <= 1'b0;
      reg_rd_en     <= 1'b0;
      spi_rsp_valid <= 1'b0;
      spi_rsp_data  <= 8'd0;
      spi_rsp_err   <= 1'b0;
      int_rsp_valid <= 1'b0;
      int_rsp_data  <= 8'd0;
      int_rsp_err   <= 1'b0;
    end else begin
      reg_wr_en     <= 1'b0;
      reg_rd_en     <= 1'b0;
      spi_rsp_valid <= 1'b0;
      int_rsp_valid <= 1'b0;
      if (grant) begin
        reg_addr    <= sel_addr;
        reg_wr_data <= sel_data;
        reg_wr_en   <= sel_we && !sel_err;
        reg_rd_en   <= !sel_we && !sel_err;
      end
      if (state == CAPT) begin
        if (lat_int) begin
          int_rsp_valid <= 1'b1;
          int_rsp_data  <= rsp_value;
          int_rsp_err   <= lat_err;
        end else begin
          spi_rsp_valid <= 1'b1;
          spi_rsp_data  <= rsp_value;
          spi_rsp_err   <= lat_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// Directed bench for spi_cfg_arbiter. The register bank is modelled as a
// one-cycle read returning addr ^ 8'h36 (and 8'hEE when not read).
module tb_spi_cfg_arbiter;

  logic       iclk = 1'b0;
  logic       rstn = 1'b0;
  logic       spi_req_valid = 1'b0, spi_req_we = 1'b0;
  logic [7:0] spi_req_addr = 8'd0, spi_req_data = 8'd0;
  logic       spi_rsp_valid, spi_rsp_err, spi_ovf;
  logic [7:0] spi_rsp_data;
  logic       ovf_clr = 1'b0;
  logic       int_req_valid = 1'b0, int_req_we = 1'b0;
  logic [7:0] int_req_addr = 8'd0, int_req_data = 8'd0;
  logic       int_req_ready, int_rsp_valid, int_rsp_err;
  logic [7:0] int_rsp_data;
  logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
  logic       reg_wr_en, reg_rd_en;

  int checks = 0;
  int errors = 0;

  spi_cfg_arbiter dut (
    .iclk(iclk), .rstn(rstn),
    .spi_req_valid(spi_req_valid), .spi_req_we(spi_req_we),
    .spi_req_addr(spi_req_addr), .spi_req_data(spi_req_data),
    .spi_rsp_valid(spi_rsp_valid), .spi_rsp_data(spi_rsp_data),
    .spi_rsp_err(spi_rsp_err), .spi_ovf(spi_ovf), .ovf_clr(ovf_clr),
    .int_req_valid(int_req_valid), .int_req_ready(int_req_ready),
    .int_req_we(int_req_we), .int_req_addr(int_req_addr),
    .int_req_data(int_req_data), .int_rsp_valid(int_rsp_valid),
    .int_rsp_data(int_rsp_data), .int_rsp_err(int_rsp_err),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data)
  );

  always #5 iclk = ~iclk;

  // Register bank model: data appears the cycle after reg_rd_en.
  always @(posedge iclk) reg_rd_data <= reg_rd_en ? (reg_addr ^ 8'h36) : 8'hEE;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge iclk); #1; end
  endtask

  task automatic spi_push(input logic we, input logic [7:0] addr, input logic [7:0] data);
    spi_req_valid = 1'b1;
    spi_req_we    = we;
    spi_req_addr  = addr;
    spi_req_data  = data;
  endtask

  // One complete SPI access starting from an idle arbiter with nothing queued.
  task automatic spi_access(input string tag, input logic we, input logic [7:0] addr,
                            input logic [7:0] data, input logic ewr, input logic erd,
                            input logic [7:0] edata, input logic eerr);
    spi_push(we, addr, data);
    tick();
    spi_req_valid = 1'b0;
    tick();
    chk({tag, ".wr_en"}, reg_wr_en, ewr);
    chk({tag, ".rd_en"}, reg_rd_en, erd);
    chk({tag, ".addr"}, reg_addr, addr);
    tick();
    chk({tag, ".strobe_off"}, reg_wr_en | reg_rd_en, 1'b0);
    chk({tag, ".early_rsp"}, spi_rsp_valid, 1'b0);
    tick();
    chk({tag, ".rsp_valid"}, spi_rsp_valid, 1'b1);
    chk({tag, ".rsp_data"}, spi_rsp_data, edata);
    chk({tag, ".rsp_err"}, spi_rsp_err, eerr);
    chk({tag, ".int_quiet"}, int_rsp_valid, 1'b0);
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst.spi_rsp_valid", spi_rsp_valid, 1'b0);
    chk("rst.int_rsp_valid", int_rsp_valid, 1'b0);
    chk("rst.int_req_ready", int_req_ready, 1'b0);
    chk("rst.strobes", reg_wr_en | reg_rd_en, 1'b0);
    chk("rst.reg_addr", reg_addr, 8'd0);
    chk("rst.spi_ovf", spi_ovf, 1'b0);
    rstn = 1'b1;
    tick();

    // SPI good write
    spi_access("spi_wr2", 1'b1, 8'd2, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0);
    chk("spi_wr2.wdata_hold", reg_wr_data, 8'hA5);
    tick();
    chk("spi_wr2.one_pulse", spi_rsp_valid, 1'b0);

    // Internal good read
    int_req_valid = 1'b1; int_req_we = 1'b0; int_req_addr = 8'd10; int_req_data = 8'h55;
    #1;
    chk("int_rd10.ready", int_req_ready, 1'b1);
    tick();
    int_req_valid = 1'b0;
    chk("int_rd10.ready_off", int_req_ready, 1'b0);
    chk("int_rd10.rd_en", reg_rd_en, 1'b1);
    chk("int_rd10.wr_en", reg_wr_en, 1'b0);
    chk("int_rd10.addr", reg_addr, 8'd10);
    tick();
    chk("int_rd10.rd_off", reg_rd_en, 1'b0);
    tick();
    chk("int_rd10.rsp_valid", int_rsp_valid, 1'b1);
    chk("int_rd10.rsp_data", int_rsp_data, 8'h3C);
    chk("int_rd10.rsp_err", int_rsp_err, 1'b0);
    chk("int_rd10.spi_quiet", spi_rsp_valid, 1'b0);

    // Map boundaries
    spi_access("spi_wr7",   1'b1, 8'd7,   8'h07, 1'b0, 1'b0, 8'h07, 1'b1);
    spi_access("spi_rd60",  1'b0, 8'd60,  8'h99, 1'b0, 1'b0, 8'h00, 1'b1);
    spi_access("spi_rd59",  1'b0, 8'd59,  8'h00, 1'b0, 1'b1, 8'h0D, 1'b0);
    spi_access("spi_wr3",   1'b1, 8'd3,   8'h3E, 1'b1, 1'b0, 8'h3E, 1'b0);
    spi_access("spi_wr0",   1'b1, 8'd0,   8'h61, 1'b0, 1'b0, 8'h61, 1'b1);
    spi_access("spi_rd0",   1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    spi_access("spi_rd128", 1'b0, 8'h80,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    spi_access("spi_rd1",   1'b0, 8'd1,   8'h00, 1'b0, 1'b1, 8'h37, 1'b0);

    // Fresh reset so the round-robin pointer favours SPI
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // Alternation with both requesters pending
    spi_push(1'b1, 8'd2, 8'h22);
    tick();
    spi_req_valid = 1'b0;
    int_req_valid = 1'b1; int_req_we = 1'b1; int_req_addr = 8'd1; int_req_data = 8'h11;
    #1;
    chk("alt.rdy_spi_first", int_req_ready, 1'b0);
    tick();
    chk("alt.g1_addr", reg_addr, 8'd2);
    chk("alt.g1_wdata", reg_wr_data, 8'h22);
    spi_push(1'b1, 8'd3, 8'h33);
    tick();
    spi_req_valid = 1'b0;
    tick();
    chk("alt.r1_valid", spi_rsp_valid, 1'b1);
    chk("alt.r1_data", spi_rsp_data, 8'h22);
    chk("alt.rdy_int", int_req_ready, 1'b1);
    tick();
    chk("alt.g2_addr", reg_addr, 8'd1);
    chk("alt.g2_wdata", reg_wr_data, 8'h11);
    int_req_data = 8'h44;
    tick(2);
    chk("alt.r2_valid", int_rsp_valid, 1'b1);
    chk("alt.r2_data", int_rsp_data, 8'h11);
    chk("alt.r2_spi_quiet", spi_rsp_valid, 1'b0);
    chk("alt.rdy_spi_again", int_req_ready, 1'b0);
    tick();
    chk("alt.g3_addr", reg_addr, 8'd3);
    chk("alt.g3_wdata", reg_wr_data, 8'h33);
    tick(2);
    chk("alt.r3_valid", spi_rsp_valid, 1'b1);
    chk("alt.r3_data", spi_rsp_data, 8'h33);
    chk("alt.rdy_int_again", int_req_ready, 1'b1);
    tick();
    int_req_valid = 1'b0;
    chk("alt.g4_wdata", reg_wr_data, 8'h44);
    tick(2);
    chk("alt.r4_valid", int_rsp_valid, 1'b1);
    chk("alt.r4_data", int_rsp_data, 8'h44);

    // Overflow: three SPI pulses while an internal access is in flight
    int_req_valid = 1'b1; int_req_we = 1'b0; int_req_addr = 8'd20;
    spi_push(1'b0, 8'd10, 8'h00);
    tick();
    int_req_valid = 1'b0;
    spi_push(1'b0, 8'd11, 8'h00);
    tick();
    spi_push(1'b0, 8'd12, 8'h00);
    tick();
    spi_req_valid = 1'b0;
    chk("ovf.set", spi_ovf, 1'b1);
    chk("ovf.int_rsp_valid", int_rsp_valid, 1'b1);
    chk("ovf.int_rsp_data", int_rsp_data, 8'h22);
    tick();
    chk("ovf.b_addr", reg_addr, 8'd10);
    chk("ovf.b_rd_en", reg_rd_en, 1'b1);
    tick(2);
    chk("ovf.b_rsp_valid", spi_rsp_valid, 1'b1);
    chk("ovf.b_rsp_data", spi_rsp_data, 8'h3C);
    tick();
    chk("ovf.c_addr", reg_addr, 8'd11);
    tick(2);
    chk("ovf.c_rsp_valid", spi_rsp_valid, 1'b1);
    chk("ovf.c_rsp_data", spi_rsp_data, 8'h3D);
    tick();
    chk("ovf.d_no_grant", reg_rd_en, 1'b0);
    tick(2);
    chk("ovf.d_no_rsp", spi_rsp_valid, 1'b0);
    chk("ovf.sticky", spi_ovf, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf.cleared", spi_ovf, 1'b0);

    // Reset in the middle of a write access
    spi_push(1'b1, 8'd3, 8'h77);
    tick();
    spi_req_valid = 1'b0;
    tick();
    chk("mid_rst.wr_en_before", reg_wr_en, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst.wr_en_async", reg_wr_en, 1'b0);
    chk("mid_rst.addr_async", reg_addr, 8'd0);
    chk("mid_rst.wdata_async", reg_wr_data, 8'd0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst.no_rsp", spi_rsp_valid | int_rsp_valid, 1'b0);
      chk("mid_rst.no_strobe", reg_wr_en | reg_rd_en, 1'b0);
    end
    spi_access("post_rst", 1'b1, 8'd1, 8'h12, 1'b1, 1'b0, 8'h12, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
